// File: rtl/ddr3_rw_sched.sv
// rtl/ddr3_rw_sched.sv - MIG UI burst scheduler: round-robin write/read arbitration with wrapping region addresses.
// Optional: define DDR3_SCHED_RD_PRIO_EN for fixed read priority instead of round-robin.
module ddr3_rw_sched #(
   parameter int ADDR_W      = 28,
   parameter int CNT_W       = 10,
   parameter int RFIFO_DEPTH = 512,
   parameter int ADDR_STEP   = 8
) (
   input  logic              ui_clk,
   input  logic              rst_n,
   input  logic              init_calib_complete,
   input  logic              app_rdy,
   input  logic              app_wdf_rdy,
   input  logic              app_rd_data_valid,
   output logic              app_en,
   output logic [2:0]        app_cmd,
   output logic [ADDR_W-1:0] app_addr,
   output logic              app_wdf_wren,
   output logic              app_wdf_end,
   output logic              rfifo_wren,
   input  logic [ADDR_W-1:0] app_addr_wr_min,
   input  logic [ADDR_W-1:0] app_addr_wr_max,
   input  logic [ADDR_W-1:0] app_addr_rd_min,
   input  logic [ADDR_W-1:0] app_addr_rd_max,
   input  logic [7:0]        wr_bust_len,
   input  logic [7:0]        rd_bust_len,
   input  logic              ddr3_read_valid,
   input  logic [CNT_W-1:0]  wfifo_rcount,
   input  logic [CNT_W-1:0]  rfifo_wcount,
   output logic              busy,
   output logic              wr_wrap,
   output logic              rd_wrap
);

   localparam logic [1:0] S_INIT  = 2'd0;
   localparam logic [1:0] S_IDLE  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_READ  = 2'd3;
   localparam logic       G_WRITE = 1'b0;
   localparam logic       G_READ  = 1'b1;
   localparam int         EW      = CNT_W + 2;

   logic [1:0]        state, state_nxt;
   logic              last_grant;
   logic [7:0]        beat_cnt, len_q;
   logic [ADDR_W-1:0] wr_addr, rd_addr;
   logic [CNT_W:0]    rd_outstanding;

   logic              wr_elig, rd_elig, pick_read;
   logic              wr_accept, rd_accept, burst_done;
   logic [EW-1:0]     rd_total;
   logic [ADDR_W:0]   wr_sum, rd_sum;
   logic              wr_hit, rd_hit;

   // Read credit counts data already in the FIFO plus data still in flight from the MIG.
   assign rd_total  = EW'(rfifo_wcount) + EW'(rd_outstanding) + EW'(rd_bust_len);
   assign wr_elig   = (wr_bust_len != 8'd0) && (EW'(wfifo_rcount) >= EW'(wr_bust_len));
   assign rd_elig   = ddr3_read_valid && (rd_bust_len != 8'd0) && (rd_total <= EW'(RFIFO_DEPTH));

`ifdef DDR3_SCHED_RD_PRIO_EN
   assign pick_read = rd_elig;
`else
   assign pick_read = rd_elig && (!wr_elig || last_grant == G_WRITE);
`endif

   assign wr_accept  = (state == S_WRITE) && app_rdy && app_wdf_rdy;
   assign rd_accept  = (state == S_READ) && app_rdy;
   assign burst_done = (wr_accept || rd_accept) && (beat_cnt == len_q - 8'd1);

   assign wr_sum = {1'b0, wr_addr} + (ADDR_W+1)'(ADDR_STEP);
   assign rd_sum = {1'b0, rd_addr} + (ADDR_W+1)'(ADDR_STEP);
   assign wr_hit = wr_sum >= {1'b0, app_addr_wr_max};
   assign rd_hit = rd_sum >= {1'b0, app_addr_rd_max};

   always_comb begin
      state_nxt = state;
      case (state)
         S_INIT:  if (init_calib_complete) state_nxt = S_IDLE;
         S_IDLE: begin
            if (!init_calib_complete) state_nxt = S_INIT;
            else if (pick_read)       state_nxt = S_READ;
            else if (wr_elig)         state_nxt = S_WRITE;
         end
         default: if (burst_done) state_nxt = init_calib_complete ? S_IDLE : S_INIT;
      endcase
   end

   always_ff @(posedge ui_clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_INIT;
         last_grant <= G_READ;
         beat_cnt   <= 8'd0;
         len_q      <= 8'd0;
         wr_addr    <= app_addr_wr_min;
         rd_addr    <= app_addr_rd_min;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && state_nxt == S_READ) begin
            len_q      <= rd_bust_len;
            last_grant <= G_READ;
         end else if (state == S_IDLE && state_nxt == S_WRITE) begin
            len_q      <= wr_bust_len;
            last_grant <= G_WRITE;
         end
         if (burst_done)                   beat_cnt <= 8'd0;
         else if (wr_accept || rd_accept)  beat_cnt <= beat_cnt + 8'd1;
         if (wr_accept) wr_addr <= wr_hit ? app_addr_wr_min : wr_sum[ADDR_W-1:0];
         if (rd_accept) rd_addr <= rd_hit ? app_addr_rd_min : rd_sum[ADDR_W-1:0];
      end
   end

   always_ff @(posedge ui_clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_outstanding <= '0;
      end else begin
         case ({rd_accept, app_rd_data_valid})
            2'b10:   rd_outstanding <= rd_outstanding + 1'b1;
            2'b01:   if (rd_outstanding != '0) rd_outstanding <= rd_outstanding - 1'b1;
            default: rd_outstanding <= rd_outstanding;
         endcase
      end
   end

   // Command strobes are combinational so acceptance lands in the cycle ready is seen.
   assign app_en       = wr_accept || rd_accept;
   assign app_cmd      = (state == S_READ) ? 3'b001 : 3'b000;
   assign app_addr     = (state == S_WRITE) ? wr_addr :
                         (state == S_READ)  ? rd_addr : '0;
   assign app_wdf_wren = wr_accept;
   assign app_wdf_end  = wr_accept;
   assign rfifo_wren   = app_rd_data_valid;
   assign busy         = (state == S_WRITE) || (state == S_READ);
   assign wr_wrap      = wr_accept && wr_hit;
   assign rd_wrap      = rd_accept && rd_hit;

endmodule
